// File: rtl/dmux_stream_if.sv
// Bundle of producer-side and consumer-side stream signals for dmux_stream.
// Handshake: a word moves on a rising edge where valid and ready are both 1;
// ready never looks at valid, and a producer holding valid without ready keeps
// its payload stable until the transfer happens.
interface dmux_stream_if #(
    parameter int WIDTH    = 16,
    parameter int SEL_BITS = 3
);
    localparam int N = 1 << SEL_BITS;

    logic [WIDTH-1:0]    in_data;
    logic [SEL_BITS-1:0] in_select;
    logic                in_bcast;
    logic                in_valid;
    logic                in_ready;
    logic [N*WIDTH-1:0]  out_data;
    logic [N-1:0]        out_valid;
    logic [N-1:0]        out_ready;
    logic [15:0]         xfer_count;

    // Producer and consumers (environment side)
    modport master (
        output in_data, in_select, in_bcast, in_valid, out_ready,
        input  in_ready, out_data, out_valid, xfer_count
    );

    // Demultiplexer side
    modport slave (
        input  in_data, in_select, in_bcast, in_valid, out_ready,
        output in_ready, out_data, out_valid, xfer_count
    );
endinterface

// File: rtl/dmux_stream.sv
// Registered N-way stream demultiplexer with one-entry output register per
// channel, broadcast mode and a 16-bit accepted-transfer counter.
module dmux_stream #(
    parameter int WIDTH    = 16,
    parameter int SEL_BITS = 3
) (
    input  logic          clk,
    input  logic          rst,
    dmux_stream_if.slave  bus
);
    localparam int N = 1 << SEL_BITS;

    logic [N-1:0]       valid_q, valid_d;
    logic [N*WIDTH-1:0] data_q, data_d;
    logic [15:0]        xfer_count_q, xfer_count_d;

    logic [N-1:0] free;
    logic [N-1:0] target;
    logic         in_ready;
    logic         accept;

    // Ready/target decode: a channel is free when empty or draining this cycle;
    // broadcast needs every channel free at once so there is no partial delivery.
    always_comb begin
        free   = ~valid_q | bus.out_ready;
        target = '0;
        if (bus.in_bcast) begin
            target = '1;
        end else begin
            target[bus.in_select] = 1'b1;
        end
        if (rst) begin
            in_ready = 1'b0;
        end else if (bus.in_bcast) begin
            in_ready = &free;
        end else begin
            in_ready = free[bus.in_select];
        end
        accept = bus.in_valid && in_ready;
    end

    // Next-state: a load into a channel wins over its drain, giving one word
    // per cycle per channel; untargeted channels only clear on drain.
    always_comb begin
        valid_d      = valid_q;
        data_d       = data_q;
        xfer_count_d = xfer_count_q;
        for (int i = 0; i < N; i++) begin
            if (accept && target[i]) begin
                valid_d[i]                = 1'b1;
                data_d[i*WIDTH +: WIDTH] = bus.in_data;
            end else if (bus.out_ready[i]) begin
                valid_d[i] = 1'b0;
            end
        end
        if (accept) begin
            xfer_count_d = xfer_count_q + 16'd1;
        end
    end

    // State registers; reset discards any in-flight word and dominates accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q      <= '0;
            data_q       <= '0;
            xfer_count_q <= '0;
        end else begin
            valid_q      <= valid_d;
            data_q       <= data_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = valid_q;
    assign bus.out_data   = data_q;
    assign bus.xfer_count = xfer_count_q;
endmodule

// File: tb/tb_dmux_stream.sv
// Testbench for dmux_stream: directed vector table, counter wrap, and random
// producer/consumer traffic checked against per-channel expected queues.
module tb_dmux_stream;
    localparam int WIDTH    = 16;
    localparam int SEL_BITS = 3;
    localparam int N        = 8;

    logic clk;
    logic rst;

    dmux_stream_if #(.WIDTH(WIDTH), .SEL_BITS(SEL_BITS)) bus ();

    dmux_stream #(.WIDTH(WIDTH), .SEL_BITS(SEL_BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: what each consumer still has to receive, in order,
    // plus the number of accepted transfers.
    logic [WIDTH-1:0] exp_q [N][$];
    logic [15:0]      exp_count;

    typedef struct {
        logic        r;
        logic        v;
        logic        b;
        logic [2:0]  s;
        logic [15:0] d;
        logic [7:0]  ordy;
        logic        exp_ready;
        logic [7:0]  exp_ovalid;
        logic [15:0] exp_count;
        logic [15:0] exp_d;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check in_ready mid-cycle against the model,
    // advance the model across the edge, then check registered outputs.
    task automatic step(input logic r, input logic v, input logic b, input logic [2:0] s,
                        input logic [15:0] d, input logic [7:0] ordy, output logic rdy_seen,
                        output logic model_rdy);
        logic all_free;
        logic acc;
        logic [7:0] exp_v;
        rst           = r;
        bus.in_valid  = v;
        bus.in_bcast  = b;
        bus.in_select = s;
        bus.in_data   = d;
        bus.out_ready = ordy;
        #4;
        all_free = 1'b1;
        for (int i = 0; i < N; i++) begin
            if (!(exp_q[i].size() == 0 || ordy[i])) all_free = 1'b0;
        end
        if (r)      model_rdy = 1'b0;
        else if (b) model_rdy = all_free;
        else        model_rdy = (exp_q[s].size() == 0) || ordy[s];
        rdy_seen = bus.in_ready;
        chk("in_ready", {31'd0, rdy_seen}, {31'd0, model_rdy});
        @(posedge clk);
        acc = v && model_rdy;
        if (r) begin
            for (int i = 0; i < N; i++) exp_q[i].delete();
            exp_count = 16'd0;
        end else begin
            for (int i = 0; i < N; i++) begin
                if (ordy[i] && exp_q[i].size() > 0) void'(exp_q[i].pop_front());
                if (acc && (b || s == 3'(i))) exp_q[i].push_back(d);
            end
            if (acc) exp_count = exp_count + 16'd1;
        end
        #1;
        exp_v = '0;
        for (int i = 0; i < N; i++) begin
            if (exp_q[i].size() > 1) begin
                errors++;
                $display("FAIL model_depth: channel %0d holds %0d words, required at most 1", i, exp_q[i].size());
            end
            exp_v[i] = (exp_q[i].size() > 0);
        end
        chk("out_valid", {24'd0, bus.out_valid}, {24'd0, exp_v});
        chk("xfer_count", {16'd0, bus.xfer_count}, {16'd0, exp_count});
        for (int i = 0; i < N; i++) begin
            if (exp_q[i].size() > 0)
                chk("out_data", {16'd0, bus.out_data[i*WIDTH +: WIDTH]}, {16'd0, exp_q[i][0]});
            else if (r)
                chk("out_data_rst", {16'd0, bus.out_data[i*WIDTH +: WIDTH]}, 32'd0);
        end
    endtask

    vec_t vecs[$];

    initial begin
        logic rdy, mrdy;
        logic p_v, p_b;
        logic [2:0] p_s;
        logic [15:0] p_d;
        logic [7:0] p_r;

        exp_count     = 16'd0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_bcast  = 1'b0;
        bus.in_select = '0;
        bus.in_data   = '0;
        bus.out_ready = '0;
        @(posedge clk);
        #1;

        // Directed table: {rst, valid, bcast, sel, data, out_ready} -> {in_ready, out_valid, count, data on sel}
        vecs.push_back('{1, 1, 0, 3'd0, 16'h5555, 8'hFF, 0, 8'h00, 16'd0, 16'h0000});
        vecs.push_back('{1, 1, 0, 3'd0, 16'h5555, 8'hFF, 0, 8'h00, 16'd0, 16'h0000});
        for (int i = 0; i < 8; i++)
            vecs.push_back('{0, 1, 0, 3'(i), 16'hA000 + 16'(i), 8'hFF, 1, 8'(1 << i), 16'(i + 1), 16'hA000 + 16'(i)});
        vecs.push_back('{0, 0, 0, 3'd0, 16'h0000, 8'hFF, 1, 8'h00, 16'd8, 16'h0000});
        vecs.push_back('{0, 1, 0, 3'd3, 16'h1111, 8'hF7, 1, 8'h08, 16'd9, 16'h1111});
        vecs.push_back('{0, 1, 0, 3'd3, 16'h2222, 8'hF7, 0, 8'h08, 16'd9, 16'h1111});
        vecs.push_back('{0, 1, 0, 3'd3, 16'h2222, 8'hFF, 1, 8'h08, 16'd10, 16'h2222});
        vecs.push_back('{0, 0, 0, 3'd3, 16'h0000, 8'hFF, 1, 8'h00, 16'd10, 16'h0000});
        vecs.push_back('{0, 1, 0, 3'd5, 16'h0505, 8'hDF, 1, 8'h20, 16'd11, 16'h0505});
        vecs.push_back('{0, 1, 1, 3'd0, 16'hBEEF, 8'hDF, 0, 8'h20, 16'd11, 16'h0000});
        vecs.push_back('{0, 1, 1, 3'd0, 16'hBEEF, 8'hDF, 0, 8'h20, 16'd11, 16'h0000});
        vecs.push_back('{0, 1, 1, 3'd0, 16'hBEEF, 8'hFF, 1, 8'hFF, 16'd12, 16'hBEEF});
        vecs.push_back('{0, 0, 0, 3'd0, 16'h0000, 8'hFF, 1, 8'h00, 16'd12, 16'h0000});
        vecs.push_back('{0, 1, 0, 3'd0, 16'h0C00, 8'h00, 1, 8'h01, 16'd13, 16'h0C00});
        vecs.push_back('{0, 1, 0, 3'd1, 16'h0C01, 8'h00, 1, 8'h03, 16'd14, 16'h0C01});
        vecs.push_back('{0, 1, 0, 3'd2, 16'h0C02, 8'h00, 1, 8'h07, 16'd15, 16'h0C02});
        vecs.push_back('{1, 1, 0, 3'd3, 16'h0C03, 8'h00, 0, 8'h00, 16'd0, 16'h0000});
        vecs.push_back('{0, 0, 0, 3'd3, 16'h0000, 8'h00, 1, 8'h00, 16'd0, 16'h0000});

        foreach (vecs[k]) begin
            step(vecs[k].r, vecs[k].v, vecs[k].b, vecs[k].s, vecs[k].d, vecs[k].ordy, rdy, mrdy);
            chk("tbl_ready", {31'd0, rdy}, {31'd0, vecs[k].exp_ready});
            chk("tbl_out_valid", {24'd0, bus.out_valid}, {24'd0, vecs[k].exp_ovalid});
            chk("tbl_count", {16'd0, bus.xfer_count}, {16'd0, vecs[k].exp_count});
            if (vecs[k].exp_ovalid[vecs[k].s])
                chk("tbl_data", {16'd0, bus.out_data[vecs[k].s*WIDTH +: WIDTH]}, {16'd0, vecs[k].exp_d});
        end

        // Counter wrap: 65535 accepts reach 0xFFFF, one more wraps to zero.
        for (int k = 0; k < 65535; k++) begin
            step(0, 1, 0, k[2:0], k[15:0], 8'hFF, rdy, mrdy);
        end
        chk("wrap_ffff", {16'd0, bus.xfer_count}, 32'h0000FFFF);
        step(0, 1, 0, 3'd4, 16'h4444, 8'hFF, rdy, mrdy);
        chk("wrap_zero", {16'd0, bus.xfer_count}, 32'h00000000);
        step(1, 0, 0, 3'd0, 16'h0000, 8'hFF, rdy, mrdy);

        // Random traffic; the producer holds its word while stalled.
        p_v = 1'b0; p_b = 1'b0; p_s = '0; p_d = '0;
        mrdy = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (!(p_v && !mrdy)) begin
                p_v = ($urandom_range(0, 3) != 0);
                p_b = ($urandom_range(0, 7) == 0);
                p_s = 3'($urandom_range(0, 7));
                p_d = 16'($urandom);
            end
            p_r = 8'($urandom | $urandom);
            step(0, p_v, p_b, p_s, p_d, p_r, rdy, mrdy);
        end

        // Drain whatever is left and confirm everything was delivered.
        for (int k = 0; k < 4; k++) step(0, 0, 0, 3'd0, 16'h0000, 8'hFF, rdy, mrdy);
        chk("final_empty", {24'd0, bus.out_valid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/dmux_stream.md
# dmux_stream

Registered, parametrised N-way stream demultiplexer. Routes each accepted input word, under valid/ready handshake, to one of `2**SEL_BITS` output channels, or to all of them in broadcast mode. Each channel has a one-entry output register and independent backpressure. It sits between a single producer (e.g. the CPU-side write path) and a bank of consumers such as memory-mapped devices or register files, and is the clocked successor to the combinational 8-way demux.

## Interface
Parameters:
- `WIDTH`, 16, data word width in bits (≥1).
- `SEL_BITS`, 3, select width; channel count `N = 2**SEL_BITS` (≥1).

Ports:
- `clk`  in  1  sole clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `in_data`  in  WIDTH  input word.
- `in_select`  in  SEL_BITS  destination channel index.
- `in_bcast`  in  1  1 = deliver to all N channels; `in_select` ignored.
- `in_valid`  in  1  producer has a word.
- `in_ready`  out  1  block accepts the word this cycle.
- `out_data`  out  N*WIDTH  channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `out_valid`  out  N  channel i holds a word.
- `out_ready`  in  N  consumer i takes its word this cycle.
- `xfer_count`  out  16  number of accepted input transfers, modulo 2^16.

## Operation
- Per-channel state: data register `d[i]`, valid flag `v[i]`.
- Channel i is *free* when `!v[i] || out_ready[i]` (empty, or draining this cycle).
- `in_ready`:
  - Unicast: `free[in_select]`.
  - Broadcast: AND of `free[i]` over all i.
  - Forced to 0 while `rst` = 1.
  - Never depends on `in_valid`.
- Accept = `in_valid && in_ready`.
- On accept, each target channel (selected one, or all if bcast) loads `d[i] <= in_data` and sets `v[i] <= 1`.
- Non-target channel, or no accept: if `out_ready[i] && v[i]`, then `v[i] <= 0`; `d[i]` is held.
- Simultaneous drain and load on the same channel: load wins. `v[i]` stays 1 and new data appears next cycle, giving back-to-back throughput of 1 word/cycle per channel.
- `out_ready[i]` with `v[i]` = 0 has no effect.
- `xfer_count` increments by 1 per accept; a broadcast counts once. Wraps 0xFFFF → 0x0000.
- Per-channel word order equals input acceptance order. No word is dropped or duplicated except by broadcast fan-out.
- Producer rule, checked by the bench: while `in_valid && !in_ready`, `in_data`, `in_select` and `in_bcast` are held stable and `in_valid` stays high.
- Consumer guarantee: once `v[i]` = 1, `d[i]` is stable until the cycle where `out_ready[i]` = 1.

## Timing
- Reset (`rst` high at a rising edge): all `out_valid` = 0, all `out_data` = 0, `xfer_count` = 0. An in-flight word in any channel is discarded. Reset dominates any simultaneous accept.
- Latency: word accepted at edge k is visible on `out_valid`/`out_data` after edge k (1 cycle).
- `in_ready` is combinational from `out_ready`, `out_valid`, `in_select`, `in_bcast` and `rst`. This is the only combinational input-to-output path.
- `out_data`, `out_valid` and `xfer_count` are purely registered.
- Broadcast stalls until every channel is free in the same cycle. There is no partial delivery.

## Test plan
- Reset then idle: `rst`=1 for 2 cycles with `in_valid`=1 → `in_ready`=0, `out_valid`=0x00, `xfer_count`=0. No load occurs.
- Unicast sweep, N=8, all `out_ready`=1: send 0xA000+i to select i for i=0..7 on consecutive cycles → channel i shows 0xA000+i one cycle after its accept, `out_valid` one-hot for one cycle each, `xfer_count`=8.
- Backpressure: `out_ready[3]`=0, send 0x1111 then 0x2222 to channel 3 → first accepted, `in_ready`=0 for the second. Raise `out_ready[3]` → 0x2222 is accepted in the same cycle that 0x1111 drains, then appears; `v[3]` never drops between the two words.
- Broadcast: `out_ready`=0xFF except bit 5 low with `v[5]`=1, `in_bcast`=1, data 0xBEEF → stalled until bit 5 rises. Then all 8 channels hold 0xBEEF, `out_valid`=0xFF, `xfer_count` +1.
- Wrap and reset mid-operation: preload `xfer_count` to 0xFFFF via 65535 accepts, accept one more → 0x0000. Then assert `rst` with 3 channels valid → all `out_valid`=0 next cycle.
- Randomised producer/consumer stall patterns with a scoreboard per channel → in-order, lossless delivery, and the stability rules above hold.
